// File: rtl/tile_pkg.sv
// Shared definitions for the compute-tile port: data width, tile opcodes
// and the sequencer state encoding.
package tile_pkg;

    localparam int DATA_W_DEF = 16;

    localparam logic [3:0] OP_NOT  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_LT   = 4'b0100;
    localparam logic [3:0] OP_GT   = 4'b0101;
    localparam logic [3:0] OP_EQ   = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_READ = 4'b1000;
    localparam logic [3:0] OP_MAC  = 4'b1111;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EXEC = 3'd1;
    localparam logic [2:0] ST_TURN = 3'd2;
    localparam logic [2:0] ST_READ = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    function automatic logic is_read_op(input logic [3:0] op);
        return op == OP_READ;
    endfunction

endpackage

// File: rtl/tile_bus_port.sv
// Tri-state driver and sample register for the shared tile operand/result bus.
module tile_bus_port #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              drive_en,
    input  logic [DATA_W-1:0] drive_data,
    input  logic              capture_en,
    output logic [DATA_W-1:0] captured,
    inout  wire  [DATA_W-1:0] bus
);

    assign bus = drive_en ? drive_data : 'z;

    always_ff @(posedge clk) begin
        if (clear) begin
            captured <= '0;
        end else if (capture_en) begin
            captured <= bus;
        end
    end

endmodule

// File: rtl/tile_sequencer.sv
// Initiator for one compute tile: accepts a command, runs EXEC/TURN/READ on
// the shared bus and returns the captured tile result on a response channel.
module tile_sequencer
    import tile_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TURN_CYCLES = 0
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [3:0]        tile_opcode,
    output logic [DATA_W-1:0] tile_input0,
    inout  wire  [DATA_W-1:0] tile_bus,
    output logic [15:0]       op_count
);

    localparam logic [1:0] TURN_LOAD = (TURN_CYCLES > 0) ? 2'(TURN_CYCLES - 1) : 2'd0;

    logic [2:0]        state;
    logic [3:0]        lat_op;
    logic [DATA_W-1:0] lat_a;
    logic [DATA_W-1:0] lat_b;
    logic [1:0]        turn_cnt;
    logic              drive_en;
    logic              capture_en;

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= ST_IDLE;
            lat_op   <= OP_READ;
            lat_a    <= '0;
            lat_b    <= '0;
            turn_cnt <= '0;
            op_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        lat_op <= cmd_op;
                        lat_a  <= cmd_a;
                        lat_b  <= cmd_b;
                        state  <= is_read_op(cmd_op) ? ST_READ : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (TURN_CYCLES > 0) begin
                        state    <= ST_TURN;
                        turn_cnt <= TURN_LOAD;
                    end else begin
                        state <= ST_READ;
                    end
                end
                ST_TURN: begin
                    if (turn_cnt == 2'd0) begin
                        state <= ST_READ;
                    end else begin
                        turn_cnt <= turn_cnt - 2'd1;
                    end
                end
                ST_READ: state <= ST_RESP;
                ST_RESP: begin
                    if (res_ready) begin
                        op_count <= op_count + 16'd1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Opcode and bus enable both decode the registered state, so the bus is
    // only ever driven while a non-read opcode is presented.
    assign cmd_ready   = (state == ST_IDLE);
    assign res_valid   = (state == ST_RESP);
    assign drive_en    = (state == ST_EXEC);
    assign capture_en  = (state == ST_READ);
    assign tile_opcode = drive_en ? lat_op : OP_READ;
    assign tile_input0 = lat_a;

    tile_bus_port #(
        .DATA_W(DATA_W)
    ) u_bus_port (
        .clk       (clk),
        .clear     (clear),
        .drive_en  (drive_en),
        .drive_data(lat_b),
        .capture_en(capture_en),
        .captured  (res_data),
        .bus       (tile_bus)
    );

endmodule
